// File: rtl/throw_trajectory.sv
// rtl/throw_trajectory.sv - projectile flight integrator with HIT/MISS classification
// Launches leftward from (X0,Y0) on throw_start, steps once per frame_tick, holds the result.
module throw_trajectory #(
  parameter int X0          = 860,
  parameter int Y0          = 400,
  parameter int GROUND_Y    = 440,
  parameter int VY_BIAS     = 4,
  parameter int GRAVITY     = 1,
  parameter int TGT_X_MIN   = 200,
  parameter int TGT_X_MAX   = 263,
  parameter int TGT_Y_MIN   = 380,
  parameter int TGT_Y_MAX   = 440,
  parameter int HOLD_FRAMES = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               throw_start,
  input  logic [9:0]         throw_force,
  output logic [10:0]        pos_x,
  output logic signed [11:0] pos_y,
  output logic               in_flight,
  output logic               busy,
  output logic               hit,
  output logic               miss
);
  typedef enum logic [1:0] {S_IDLE, S_FLIGHT, S_HIT, S_MISS} state_t;

  localparam int CW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  localparam logic [10:0]        X0_V    = 11'(X0);
  localparam logic signed [11:0] Y0_V    = 12'(Y0);
  localparam logic signed [11:0] GND12   = 12'(GROUND_Y);
  localparam logic signed [12:0] GND13   = 13'(GROUND_Y);
  localparam logic signed [11:0] BIAS_V  = 12'(VY_BIAS);
  localparam logic signed [11:0] GRAV_V  = 12'(GRAVITY);
  localparam logic signed [12:0] TXMIN_V = 13'(TGT_X_MIN);
  localparam logic signed [12:0] TXMAX_V = 13'(TGT_X_MAX);
  localparam logic signed [12:0] TYMIN_V = 13'(TGT_Y_MIN);
  localparam logic signed [12:0] TYMAX_V = 13'(TGT_Y_MAX);
  localparam logic [CW-1:0]      HOLD_LAST = CW'(HOLD_FRAMES - 1);

  state_t                state_q, state_d;
  logic [10:0]           px_q, px_d;
  logic signed [11:0]    py_q, py_d;
  logic [6:0]            vx_q, vx_d;
  logic signed [11:0]    vy_q, vy_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  in_flight_q, in_flight_d;
  logic                  busy_q, busy_d;
  logic                  hit_q, hit_d;
  logic                  miss_q, miss_d;

  logic signed [12:0]    nx, ny, ny_clip;
  logic                  left_out, in_box;

  // One extra bit keeps the candidate position comparisons free of wraparound.
  always_comb begin
    nx       = $signed({2'b00, px_q}) - $signed({6'b000000, vx_q});
    ny       = $signed({py_q[11], py_q}) + $signed({vy_q[11], vy_q});
    ny_clip  = (ny >= GND13) ? GND13 : ny;
    left_out = (px_q < {4'b0000, vx_q});
    in_box   = (nx >= TXMIN_V) && (nx <= TXMAX_V) &&
               (ny_clip >= TYMIN_V) && (ny_clip <= TYMAX_V);
  end

  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    py_d    = py_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    cnt_d   = cnt_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (throw_start) begin
          vx_d    = 7'(throw_force >> 3);
          vy_d    = -($signed(12'(throw_force >> 3)) + BIAS_V);
          px_d    = X0_V;
          py_d    = Y0_V;
          state_d = S_FLIGHT;
        end
      end
      S_FLIGHT: begin
        if (frame_tick) begin
          if (left_out) begin
            px_d    = '0;
            py_d    = ny[11:0];
            state_d = S_MISS;
            miss_d  = 1'b1;
            cnt_d   = '0;
          end else if (in_box) begin
            px_d    = nx[10:0];
            py_d    = ny_clip[11:0];
            state_d = S_HIT;
            hit_d   = 1'b1;
            cnt_d   = '0;
          end else if (ny >= GND13) begin
            px_d    = nx[10:0];
            py_d    = GND12;
            state_d = S_MISS;
            miss_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            px_d = nx[10:0];
            py_d = ny[11:0];
            vy_d = vy_q + GRAV_V;
          end
        end
      end
      S_HIT, S_MISS: begin
        if (frame_tick) begin
          if (cnt_q == HOLD_LAST) begin
            state_d = S_IDLE;
            px_d    = X0_V;
            py_d    = Y0_V;
            vx_d    = '0;
            vy_d    = '0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_flight_d = (state_d == S_FLIGHT);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      px_q        <= X0_V;
      py_q        <= Y0_V;
      vx_q        <= '0;
      vy_q        <= '0;
      cnt_q       <= '0;
      in_flight_q <= 1'b0;
      busy_q      <= 1'b0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      px_q        <= px_d;
      py_q        <= py_d;
      vx_q        <= vx_d;
      vy_q        <= vy_d;
      cnt_q       <= cnt_d;
      in_flight_q <= in_flight_d;
      busy_q      <= busy_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
    end
  end

  assign pos_x     = px_q;
  assign pos_y     = py_q;
  assign in_flight = in_flight_q;
  assign busy      = busy_q;
  assign hit       = hit_q;
  assign miss      = miss_q;
endmodule

// File: tb/tb_throw_trajectory.sv
// tb/tb_throw_trajectory.sv - directed and random throws against a closed-form trajectory model
// Instance a uses default parameters; instance b has a distant ground and an unreachable target.
module tb_throw_trajectory;
  localparam int X0 = 860;
  localparam int Y0 = 400;
  localparam int HOLD = 30;
  localparam int RES_MISS = 0;
  localparam int RES_HIT = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_tick = 1'b0;
  logic ts_a = 1'b0;
  logic ts_b = 1'b0;
  logic [9:0] frc = '0;

  logic [10:0] px_a, px_b;
  logic signed [11:0] py_a, py_b;
  logic fl_a, fl_b, bz_a, bz_b, hit_a, hit_b, miss_a, miss_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  throw_trajectory u_a (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .throw_start(ts_a), .throw_force(frc),
    .pos_x(px_a), .pos_y(py_a), .in_flight(fl_a), .busy(bz_a), .hit(hit_a), .miss(miss_a)
  );

  throw_trajectory #(.GROUND_Y(1000), .TGT_X_MIN(2000), .TGT_X_MAX(2047)) u_b (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .throw_start(ts_b), .throw_force(frc),
    .pos_x(px_b), .pos_y(py_b), .in_flight(fl_b), .busy(bz_b), .hit(hit_b), .miss(miss_b)
  );

  function automatic int ox(input int sel);
    return (sel != 0) ? int'(px_b) : int'(px_a);
  endfunction

  function automatic int oy(input int sel);
    return (sel != 0) ? int'(py_b) : int'(py_a);
  endfunction

  // flags encoding: in_flight*8 + busy*4 + hit*2 + miss
  function automatic int flags(input int sel);
    if (sel != 0) return int'({fl_b, bz_b, hit_b, miss_b});
    return int'({fl_a, bz_a, hit_a, miss_a});
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    frame_tick = 1'b1;
    cycles(1);
    frame_tick = 1'b0;
  endtask

  // Closed-form flight: after k frames x = X0 - vx*k, y = Y0 + vy0*k + k(k-1)/2.
  function automatic void predict(input int f, input int ground, input int txmin, input int txmax,
                                  output int n, output int res, output int fx, output int fy);
    int vx, vy0, xp, x, y, yc;
    vx = f / 8;
    vy0 = -(vx + 4);
    n = 0; res = RES_MISS; fx = 0; fy = 0;
    for (int k = 1; k < 2000; k++) begin
      xp = X0 - vx * (k - 1);
      x  = X0 - vx * k;
      y  = Y0 + vy0 * k + (k * (k - 1)) / 2;
      yc = (y < ground) ? y : ground;
      if (xp < vx) begin
        n = k; res = RES_MISS; fx = 0; fy = y; return;
      end
      if (x >= txmin && x <= txmax && yc >= 380 && yc <= 440) begin
        n = k; res = RES_HIT; fx = x; fy = yc; return;
      end
      if (y >= ground) begin
        n = k; res = RES_MISS; fx = x; fy = ground; return;
      end
    end
  endfunction

  task automatic fly(input int sel, input int f, input int ground, input int txmin, input int txmax,
                     input bit with_tick, input int junk_at, input int rst_at, input string nm,
                     output int fx_o, output int fy_o);
    int n, res, fx, fy, vx, vy0, end_flags;
    vx = f / 8;
    vy0 = -(vx + 4);
    predict(f, ground, txmin, txmax, n, res, fx, fy);
    end_flags = (res == RES_HIT) ? 6 : 5;
    frc = 10'(f);
    if (sel != 0) ts_b = 1'b1; else ts_a = 1'b1;
    frame_tick = with_tick;
    cycles(1);
    ts_a = 1'b0; ts_b = 1'b0; frame_tick = 1'b0;
    chk({nm, "_launch_x"}, ox(sel), X0);
    chk({nm, "_launch_y"}, oy(sel), Y0);
    chk({nm, "_launch_flags"}, flags(sel), 12);
    cycles(1 + int'($urandom_range(0, 2)));
    for (int k = 1; k <= n; k++) begin
      if (k == rst_at) begin
        rst = 1'b1;
        #1;
        chk({nm, "_rst_x"}, ox(sel), X0);
        chk({nm, "_rst_y"}, oy(sel), Y0);
        chk({nm, "_rst_flags"}, flags(sel), 0);
        cycles(1);
        rst = 1'b0;
        cycles(1);
        fx_o = ox(sel); fy_o = oy(sel);
        return;
      end
      if (k == junk_at) begin
        if (sel != 0) ts_b = 1'b1; else ts_a = 1'b1;
        frc = 10'd100;
      end
      do_tick();
      ts_a = 1'b0; ts_b = 1'b0; frc = 10'(f);
      if (k < n) begin
        chk($sformatf("%s_t%0d_x", nm, k), ox(sel), X0 - vx * k);
        chk($sformatf("%s_t%0d_y", nm, k), oy(sel), Y0 + vy0 * k + (k * (k - 1)) / 2);
        chk($sformatf("%s_t%0d_flags", nm, k), flags(sel), 12);
      end else begin
        chk($sformatf("%s_end_x", nm), ox(sel), fx);
        chk($sformatf("%s_end_y", nm), oy(sel), fy);
        chk($sformatf("%s_end_flags", nm), flags(sel), end_flags);
      end
      cycles(1 + int'($urandom_range(0, 2)));
    end
    fx_o = ox(sel); fy_o = oy(sel);
    chk({nm, "_pulse_gone"}, flags(sel), 4);
    for (int h = 1; h <= HOLD; h++) begin
      do_tick();
      if (h < HOLD) begin
        chk($sformatf("%s_hold%0d_flags", nm, h), flags(sel), 4);
        chk($sformatf("%s_hold%0d_x", nm, h), ox(sel), fx);
      end else begin
        chk({nm, "_rearm_flags"}, flags(sel), 0);
        chk({nm, "_rearm_x"}, ox(sel), X0);
        chk({nm, "_rearm_y"}, oy(sel), Y0);
      end
      cycles(1 + int'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fx, fy;
    // throw_start during reset must not launch
    ts_a = 1'b1; ts_b = 1'b1; frc = 10'd500;
    cycles(3);
    ts_a = 1'b0; ts_b = 1'b0;
    rst = 1'b0;
    cycles(1);
    chk("reset_x", ox(0), X0);
    chk("reset_y", oy(0), Y0);
    chk("reset_flags", flags(0), 0);
    chk("reset_flags_b", flags(1), 0);
    do_tick();
    cycles(1);
    chk("idle_after_reset", flags(0), 0);

    fly(0, 64, 440, 200, 263, 1'b0, 0, 0, "s2", fx, fy);
    chk("s2_final_x", fx, 636);
    chk("s2_final_y", fy, 440);

    fly(0, 128, 440, 200, 263, 1'b0, 0, 0, "s3", fx, fy);
    chk("s3_final_x", fx, 220);
    chk("s3_final_y", fy, 380);

    fly(1, 128, 1000, 2000, 2047, 1'b0, 0, 0, "s4", fx, fy);
    chk("s4_final_x", fx, 0);
    chk("s4_final_y", fy, 751);

    fly(0, 64, 440, 200, 263, 1'b0, 10, 0, "s5_junk", fx, fy);
    chk("s5_junk_final_x", fx, 636);
    fly(0, 64, 440, 200, 263, 1'b1, 0, 0, "s5_cotick", fx, fy);
    chk("s5_cotick_final_x", fx, 636);

    fly(0, 64, 440, 200, 263, 1'b0, 0, 15, "s6_rst", fx, fy);
    chk("s6_post_rst_flags", flags(0), 0);
    fly(0, 64, 440, 200, 263, 1'b0, 0, 0, "s6_again", fx, fy);
    chk("s6_again_final_x", fx, 636);

    fly(0, 0, 440, 200, 263, 1'b0, 0, 0, "zero", fx, fy);
    chk("zero_final_x", fx, 860);
    chk("zero_final_y", fy, 440);

    for (int r = 0; r < 12; r++) begin
      fly(0, int'($urandom_range(0, 1023)), 440, 200, 263, 1'(r % 2), 0, 0,
          $sformatf("rnd%0d", r), fx, fy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/throw_trajectory.md
Name: throw_trajectory

Overview:
- Consumer of the power-bar throw force: on a launch strobe, captures the 10-bit force and flies a projectile leftward from a fixed origin.
- Integrates velocity and gravity once per video frame and reports the projectile position to the downstream sprite renderer.
- Classifies each throw as HIT (enters the target box) or MISS (reaches ground or left screen edge), holds the result, then rearms.
- Sits between the power-bar logic and the projectile draw/score logic, in the 65 MHz pixel-clock domain.

Parameters:
- X0, 860, launch x (pixels)
- Y0, 400, launch y (pixels)
- GROUND_Y, 440, landing line; y >= GROUND_Y is ground
- VY_BIAS, 4, extra upward launch speed (px/frame)
- GRAVITY, 1, added to vy every frame
- TGT_X_MIN, 200, target box left edge, inclusive
- TGT_X_MAX, 263, target box right edge, inclusive
- TGT_Y_MIN, 380, target box top edge, inclusive
- TGT_Y_MAX, 440, target box bottom edge, inclusive
- HOLD_FRAMES, 30, frames the HIT/MISS result is held before returning to IDLE

Ports:
- clk, in, 1, pixel clock
- rst, in, 1, reset: asynchronous, active-high
- frame_tick, in, 1, one-cycle pulse per frame (vsync rising edge)
- throw_start, in, 1, one-cycle launch strobe (space release)
- throw_force, in, 10, force, valid in the cycle throw_start is high
- pos_x, out, 11, projectile x, unsigned
- pos_y, out, 12, projectile y, signed two's complement
- in_flight, out, 1, high in FLIGHT
- busy, out, 1, high in any state except IDLE
- hit, out, 1, one-cycle pulse on entering HIT
- miss, out, 1, one-cycle pulse on entering MISS

Behaviour:
- Reset (async): state IDLE; pos_x=X0, pos_y=Y0, vx=0, vy=0, hold counter 0; in_flight, busy, hit and miss all 0.
- States: IDLE, FLIGHT, HIT, MISS.
- IDLE, on throw_start=1 in clk cycle t:
  - vx <= throw_force>>3 (0..127, 7-bit unsigned).
  - vy <= -((throw_force>>3)+VY_BIAS), signed 12-bit.
  - pos = (X0,Y0); state FLIGHT from cycle t+1.
  - A frame_tick coincident with throw_start does not move the projectile; the first motion occurs on the next frame_tick.
- throw_start outside IDLE is ignored. Force is not re-captured.
- FLIGHT, on each frame_tick, compute candidates nx = pos_x - vx and ny = pos_y + vy. Register updates are single-cycle, and the outputs change the cycle after the tick. Evaluate in this priority order:
  1. If pos_x < vx (left-edge underflow): pos_x <= 0, pos_y <= ny, go to MISS.
  2. Else if TGT_X_MIN <= nx <= TGT_X_MAX and TGT_Y_MIN <= min(ny,GROUND_Y) <= TGT_Y_MAX: pos <= (nx, min(ny,GROUND_Y)), go to HIT. A hit takes priority over ground contact in the same tick.
  3. Else if ny >= GROUND_Y: pos <= (nx, GROUND_Y), go to MISS.
  4. Else: pos <= (nx, ny), vy <= vy + GRAVITY, stay in FLIGHT.
- Negative pos_y (above the screen) is legal; it is not a miss.
- hit/miss pulse for exactly one cycle, aligned with the state-entry cycle.
- HIT and MISS:
  - pos frozen; hold counter clears on entry and increments per frame_tick.
  - When the counter reaches HOLD_FRAMES-1 and a frame_tick arrives: go to IDLE, pos <= (X0,Y0), vx=vy=0.
- Reset mid-flight returns immediately to the reset values. No hit/miss pulse is generated.
- Zero force: vx=0, vy0=-VY_BIAS. The projectile rises and falls vertically, landing at (X0, GROUND_Y) → MISS.

Test Plan:
1. Reset release → pos=(860,400), busy=0, hit=miss=0. throw_start while rst=1 has no effect.
2. force=64 (vx=8, vy0=-12), defaults → MISS pulse after the 28th frame_tick, pos=(636,440). busy drops after 30 further ticks and pos returns to (860,400).
3. force=128 (vx=16, vy0=-20), defaults:
   - Tick 39: pos=(236,361), still FLIGHT.
   - Tick 40: HIT pulse, pos=(220,380).
   - No miss pulse follows.
4. force=128, GROUND_Y=1000, target moved off-path → MISS on the 54th tick (pos_x was 12 < 16), pos_x=0.
5. throw_start with force=100 mid-flight (tick 10 of the scenario-2 throw) → ignored; trajectory identical to scenario 2. throw_start coincident with frame_tick in IDLE → first position change on the following tick.
6. Async rst asserted at tick 15 of a flight → same cycle: pos=(860,400), in_flight=0, no hit/miss pulse. A new throw after release behaves as in scenario 2.
